// File: rtl/control_sequencer_if.sv
// Control-sequencer bus bundle.
// The master side is the sequencer: it consumes the instruction, condition
// flag and halt request, and drives every datapath control line.
// The slave side is the datapath, which sees the same signals with the
// opposite directions.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        con_ff;
  logic        stop;
  logic [7:0]  bus_src;
  logic [5:0]  reg_ctl;
  logic [9:0]  ld_en;
  logic [1:0]  mem_ctl;
  logic [12:0] alu_op;
  logic        run;
  logic [2:0]  step;

  modport master (
    input  IR, con_ff, stop,
    output bus_src, reg_ctl, ld_en, mem_ctl, alu_op, run, step
  );

  modport slave (
    output IR, con_ff, stop,
    input  bus_src, reg_ctl, ld_en, mem_ctl, alu_op, run, step
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: a fetch (T0..T2) is followed by an
// opcode-dependent execute (T3..T7). All outputs decode registered state only:
// the state, the opcode captured on the edge into T3, and the branch flag
// captured on the edge into T6.
// Optional feature: define CTRL_SEQ_MULDIV_EN to sequence mul/div. Without it,
// those opcodes run as nop.
module control_sequencer (
  input logic              clk,
  input logic              clear,
  control_sequencer_if.master ctl
);

  // bus_src bit positions
  localparam int B_COUT = 7, B_INPORT = 6, B_MDROUT = 5, B_PCOUT = 4;
  localparam int B_ZLOW = 3, B_ZHIGH = 2, B_LOOUT = 1, B_HIOUT = 0;
  // reg_ctl bit positions
  localparam int B_GRA = 5, B_GRB = 4, B_GRC = 3, B_RIN = 2, B_ROUT = 1, B_BAOUT = 0;
  // ld_en bit positions
  localparam int B_CONIN = 9, B_OUTPORT = 8, B_MDRIN = 7, B_ZIN = 6, B_LOIN = 5;
  localparam int B_HIIN = 4, B_YIN = 3, B_MARIN = 2, B_IRIN = 1, B_PCIN = 0;
  // mem_ctl bit positions
  localparam int B_WRITE = 1, B_READ = 0;
  // alu_op bit positions
  localparam int B_INCPC = 12, B_NOT = 11, B_NEG = 10, B_ROL = 9, B_ROR = 8;
  localparam int B_SHL = 7, B_SHR = 6, B_DIV = 5, B_MUL = 4, B_SUB = 3;
  localparam int B_ADD = 2, B_OR = 1, B_AND = 0;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Instruction classes sharing one step sequence
  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_IMM, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_MULDIV
  } cls_t;

  state_t      state_reg, state_next;
  logic [4:0]  opcode_reg;
  logic        con_reg;
  logic        stop_reg;

  cls_t        cls;
  state_t      last_state;
  logic [12:0] op_bit;
  logic        in_seq;

  logic [7:0]  src;
  logic [5:0]  rctl;
  logic [9:0]  ld;
  logic [1:0]  mem;
  logic [12:0] alu;
  logic        run_dec;
  logic [2:0]  step_dec;

  assign in_seq = (state_reg != S_RST) && (state_reg != S_HALT);

  // State register plus the opcode, branch flag and sticky halt request it depends on
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg  <= S_RST;
      opcode_reg <= 5'd0;
      con_reg    <= 1'b0;
      stop_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_T2)
        opcode_reg <= ctl.IR[31:27];
      if (state_reg == S_T5)
        con_reg <= ctl.con_ff;
      // A stop seen anywhere in the instruction is held until its last step
      if (in_seq)
        stop_reg <= (state_reg == last_state) ? 1'b0 : (stop_reg | ctl.stop);
    end
  end

  // Opcode classification: sequence class, ALU function bit and final step
  always_comb begin
    cls    = C_NOP;
    op_bit = '0;
    case (opcode_reg)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b00011: begin cls = C_ALU;   op_bit[B_ADD] = 1'b1; end
      5'b00100: begin cls = C_ALU;   op_bit[B_SUB] = 1'b1; end
      5'b00101: begin cls = C_ALU;   op_bit[B_AND] = 1'b1; end
      5'b00110: begin cls = C_ALU;   op_bit[B_OR]  = 1'b1; end
      5'b00111: begin cls = C_ALU;   op_bit[B_SHR] = 1'b1; end
      5'b01000: begin cls = C_ALU;   op_bit[B_SHL] = 1'b1; end
      5'b01001: begin cls = C_ALU;   op_bit[B_ROR] = 1'b1; end
      5'b01010: begin cls = C_ALU;   op_bit[B_ROL] = 1'b1; end
      5'b01011: begin cls = C_IMM;   op_bit[B_ADD] = 1'b1; end
      5'b01100: begin cls = C_IMM;   op_bit[B_AND] = 1'b1; end
      5'b01101: begin cls = C_IMM;   op_bit[B_OR]  = 1'b1; end
`ifdef CTRL_SEQ_MULDIV_EN
      5'b01110: begin cls = C_MULDIV; op_bit[B_MUL] = 1'b1; end
      5'b01111: begin cls = C_MULDIV; op_bit[B_DIV] = 1'b1; end
`else
      // mul/div hardware absent: these opcodes fall through to nop
`endif
      5'b10000: begin cls = C_UNARY; op_bit[B_NEG] = 1'b1; end
      5'b10001: begin cls = C_UNARY; op_bit[B_NOT] = 1'b1; end
      5'b10010: cls = C_BR;
      5'b10011: cls = C_JR;
      5'b10100: cls = C_JAL;
      5'b10101: cls = C_IN;
      5'b10110: cls = C_OUT;
      5'b10111: cls = C_MFHI;
      5'b11000: cls = C_MFLO;
      5'b11010: cls = C_HALT;
      default:  cls = C_NOP;
    endcase

    case (cls)
      C_ALU, C_IMM, C_LDI: last_state = S_T5;
      C_UNARY, C_JAL:      last_state = S_T4;
      C_LD, C_ST:          last_state = S_T7;
      C_BR, C_MULDIV:      last_state = S_T6;
      default:             last_state = S_T3;
    endcase
  end

  // Next state: step forward until the class's last step, then refetch or halt
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:  state_next = S_T0;
      S_HALT: state_next = S_HALT;
      default: begin
        if (state_reg == last_state) begin
          if (cls == C_HALT || ctl.stop || stop_reg)
            state_next = S_HALT;
          else
            state_next = S_T0;
        end else begin
          state_next = state_t'(state_reg + 4'd1);
        end
      end
    endcase
  end

  // Output decode from registered state, opcode class and branch flag
  always_comb begin
    src      = '0;
    rctl     = '0;
    ld       = '0;
    mem      = '0;
    alu      = '0;
    run_dec  = in_seq;
    step_dec = 3'd0;
    case (state_reg)
      S_T0: begin
        step_dec = 3'd0;
        src[B_PCOUT] = 1'b1; ld[B_MARIN] = 1'b1; ld[B_ZIN] = 1'b1; alu[B_INCPC] = 1'b1;
      end
      S_T1: begin
        step_dec = 3'd1;
        src[B_ZLOW] = 1'b1; ld[B_PCIN] = 1'b1; mem[B_READ] = 1'b1; ld[B_MDRIN] = 1'b1;
      end
      S_T2: begin
        step_dec = 3'd2;
        src[B_MDROUT] = 1'b1; ld[B_IRIN] = 1'b1;
      end
      S_T3: begin
        step_dec = 3'd3;
        case (cls)
          C_ALU, C_IMM: begin rctl[B_GRB] = 1'b1; rctl[B_ROUT] = 1'b1; ld[B_YIN] = 1'b1; end
          C_UNARY:      begin rctl[B_GRB] = 1'b1; rctl[B_ROUT] = 1'b1; alu = op_bit; ld[B_ZIN] = 1'b1; end
          C_LD, C_LDI, C_ST: begin rctl[B_GRB] = 1'b1; rctl[B_BAOUT] = 1'b1; ld[B_YIN] = 1'b1; end
          C_BR:     begin rctl[B_GRA] = 1'b1; rctl[B_ROUT] = 1'b1; ld[B_CONIN] = 1'b1; end
          C_JR:     begin rctl[B_GRA] = 1'b1; rctl[B_ROUT] = 1'b1; ld[B_PCIN] = 1'b1; end
          C_JAL:    begin src[B_PCOUT] = 1'b1; rctl[B_GRB] = 1'b1; rctl[B_RIN] = 1'b1; end
          C_IN:     begin src[B_INPORT] = 1'b1; rctl[B_GRA] = 1'b1; rctl[B_RIN] = 1'b1; end
          C_OUT:    begin rctl[B_GRA] = 1'b1; rctl[B_ROUT] = 1'b1; ld[B_OUTPORT] = 1'b1; end
          C_MFHI:   begin src[B_HIOUT] = 1'b1; rctl[B_GRA] = 1'b1; rctl[B_RIN] = 1'b1; end
          C_MFLO:   begin src[B_LOOUT] = 1'b1; rctl[B_GRA] = 1'b1; rctl[B_RIN] = 1'b1; end
          C_MULDIV: begin rctl[B_GRA] = 1'b1; rctl[B_ROUT] = 1'b1; ld[B_YIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        step_dec = 3'd4;
        case (cls)
          C_ALU:    begin rctl[B_GRC] = 1'b1; rctl[B_ROUT] = 1'b1; alu = op_bit; ld[B_ZIN] = 1'b1; end
          C_IMM:    begin src[B_COUT] = 1'b1; alu = op_bit; ld[B_ZIN] = 1'b1; end
          C_UNARY:  begin src[B_ZLOW] = 1'b1; rctl[B_GRA] = 1'b1; rctl[B_RIN] = 1'b1; end
          C_LD, C_LDI, C_ST: begin src[B_COUT] = 1'b1; alu[B_ADD] = 1'b1; ld[B_ZIN] = 1'b1; end
          C_BR:     begin src[B_PCOUT] = 1'b1; ld[B_YIN] = 1'b1; end
          C_JAL:    begin rctl[B_GRA] = 1'b1; rctl[B_ROUT] = 1'b1; ld[B_PCIN] = 1'b1; end
          C_MULDIV: begin rctl[B_GRB] = 1'b1; rctl[B_ROUT] = 1'b1; alu = op_bit; ld[B_ZIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        step_dec = 3'd5;
        case (cls)
          C_ALU, C_IMM, C_LDI: begin src[B_ZLOW] = 1'b1; rctl[B_GRA] = 1'b1; rctl[B_RIN] = 1'b1; end
          C_LD, C_ST: begin src[B_ZLOW] = 1'b1; ld[B_MARIN] = 1'b1; end
          C_BR:       begin src[B_COUT] = 1'b1; alu[B_ADD] = 1'b1; ld[B_ZIN] = 1'b1; end
          C_MULDIV:   begin src[B_ZLOW] = 1'b1; ld[B_LOIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        step_dec = 3'd6;
        case (cls)
          C_LD:     begin mem[B_READ] = 1'b1; ld[B_MDRIN] = 1'b1; end
          C_ST:     begin rctl[B_GRA] = 1'b1; rctl[B_ROUT] = 1'b1; ld[B_MDRIN] = 1'b1; end
          C_BR:     begin src[B_ZLOW] = 1'b1; ld[B_PCIN] = con_reg; end
          C_MULDIV: begin src[B_ZHIGH] = 1'b1; ld[B_HIIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        step_dec = 3'd7;
        case (cls)
          C_LD:    begin src[B_MDROUT] = 1'b1; rctl[B_GRA] = 1'b1; rctl[B_RIN] = 1'b1; end
          C_ST:    mem[B_WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ctl.bus_src = src;
  assign ctl.reg_ctl = rctl;
  assign ctl.ld_en   = ld;
  assign ctl.mem_ctl = mem;
  assign ctl.alu_op  = alu;
  assign ctl.run     = run_dec;
  assign ctl.step    = step_dec;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a vector table of (instruction, step)
// -> expected control word, plus hand-written multi-cycle sequences for
// store write width, halt, stop, mid-instruction clear and mul/div gating.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic clear = 1'b1;

  control_sequencer_if sif();

  control_sequencer dut (
    .clk   (clk),
    .clear (clear),
    .ctl   (sif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mul_seen = 0;

  localparam logic [7:0] S_COUT = 8'h80, S_IN = 8'h40, S_MDR = 8'h20, S_PC = 8'h10;
  localparam logic [7:0] S_ZLO = 8'h08, S_ZHI = 8'h04, S_LO = 8'h02, S_HI = 8'h01;
  localparam logic [5:0] R_GRA = 6'h20, R_GRB = 6'h10, R_GRC = 6'h08, R_RIN = 6'h04, R_ROUT = 6'h02, R_BA = 6'h01;
  localparam logic [9:0] L_CON = 10'h200, L_OUT = 10'h100, L_MDR = 10'h080, L_Z = 10'h040, L_LO = 10'h020;
  localparam logic [9:0] L_HI = 10'h010, L_Y = 10'h008, L_MAR = 10'h004, L_IR = 10'h002, L_PC = 10'h001;
  localparam logic [1:0] M_WR = 2'b10, M_RD = 2'b01;
  localparam logic [12:0] A_INC = 13'h1000, A_NOT = 13'h0800, A_ROL = 13'h0200;
  localparam logic [12:0] A_DIV = 13'h0020, A_MUL = 13'h0010, A_SUB = 13'h0008, A_ADD = 13'h0004;

  typedef struct {
    logic [31:0] ir;
    logic        con;
    int          k;
    logic        run;
    logic [2:0]  step;
    logic [7:0]  src;
    logic [5:0]  rc;
    logic [9:0]  ld;
    logic [1:0]  mem;
    logic [12:0] alu;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [42:0] dut_out();
    return {sif.run, sif.step, sif.bus_src, sif.reg_ctl, sif.ld_en, sif.mem_ctl, sif.alu_op};
  endfunction

  task automatic check(input string name, input logic [42:0] got, input logic [42:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] ir, input logic con, input int k, input logic run,
                     input logic [2:0] step, input logic [7:0] src, input logic [5:0] rc,
                     input logic [9:0] ld, input logic [1:0] mem, input logic [12:0] alu);
    vec_t v;
    v.ir = ir; v.con = con; v.k = k; v.run = run; v.step = step;
    v.src = src; v.rc = rc; v.ld = ld; v.mem = mem; v.alu = alu;
    vecs.push_back(v);
  endtask

  // Reset, load IR/con_ff, release clear; returns on the edge that enters T0
  task automatic start(input logic [31:0] ir, input logic con);
    clear = 1'b1;
    sif.stop = 1'b0;
    @(negedge clk);
    sif.IR = ir;
    sif.con_ff = con;
    clear = 1'b0;
    @(posedge clk);
  endtask

  // MUL/DIV bit activity over the whole run
  always @(negedge clk) begin
    if (sif.alu_op[4] || sif.alu_op[5])
      mul_seen <= mul_seen + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    int wcycle;
    int wr_seen;
    sif.IR = 32'd0;
    sif.con_ff = 1'b0;
    sif.stop = 1'b0;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", dut_out(), 43'd0);

    // ir, con, k (cycles after T0), run, step, bus_src, reg_ctl, ld_en, mem_ctl, alu_op
    add(32'h18000000, 0, 0, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h18000000, 0, 1, 1, 1, S_ZLO, 0,             L_PC | L_MDR, M_RD, 0);
    add(32'h18000000, 0, 2, 1, 2, S_MDR, 0,             L_IR,         0,    0);
    add(32'h18000000, 0, 3, 1, 3, 0,     R_GRB | R_ROUT, L_Y,         0,    0);
    add(32'h18000000, 0, 4, 1, 4, 0,     R_GRC | R_ROUT, L_Z,         0,    A_ADD);
    add(32'h18000000, 0, 5, 1, 5, S_ZLO, R_GRA | R_RIN,  0,           0,    0);
    add(32'h18000000, 0, 6, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h20000000, 0, 4, 1, 4, 0,     R_GRC | R_ROUT, L_Z,         0,    A_SUB);
    add(32'h50000000, 0, 4, 1, 4, 0,     R_GRC | R_ROUT, L_Z,         0,    A_ROL);
    add(32'h58000000, 0, 4, 1, 4, S_COUT, 0,            L_Z,          0,    A_ADD);
    add(32'h58000000, 0, 5, 1, 5, S_ZLO, R_GRA | R_RIN,  0,           0,    0);
    add(32'h88000000, 0, 3, 1, 3, 0,     R_GRB | R_ROUT, L_Z,         0,    A_NOT);
    add(32'h88000000, 0, 4, 1, 4, S_ZLO, R_GRA | R_RIN,  0,           0,    0);
    add(32'h88000000, 0, 5, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h00000000, 0, 3, 1, 3, 0,     R_GRB | R_BA,   L_Y,         0,    0);
    add(32'h00000000, 0, 4, 1, 4, S_COUT, 0,            L_Z,          0,    A_ADD);
    add(32'h00000000, 0, 5, 1, 5, S_ZLO, 0,             L_MAR,        0,    0);
    add(32'h00000000, 0, 6, 1, 6, 0,     0,             L_MDR,        M_RD, 0);
    add(32'h00000000, 0, 7, 1, 7, S_MDR, R_GRA | R_RIN,  0,           0,    0);
    add(32'h00000000, 0, 8, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h08000000, 0, 5, 1, 5, S_ZLO, R_GRA | R_RIN,  0,           0,    0);
    add(32'h08000000, 0, 6, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h10000000, 0, 6, 1, 6, 0,     R_GRA | R_ROUT, L_MDR,       0,    0);
    add(32'h10000000, 0, 7, 1, 7, 0,     0,             0,            M_WR, 0);
    add(32'h90000000, 0, 3, 1, 3, 0,     R_GRA | R_ROUT, L_CON,       0,    0);
    add(32'h90000000, 0, 4, 1, 4, S_PC,  0,             L_Y,          0,    0);
    add(32'h90000000, 0, 5, 1, 5, S_COUT, 0,            L_Z,          0,    A_ADD);
    add(32'h90000000, 0, 6, 1, 6, S_ZLO, 0,             0,            0,    0);
    add(32'h90000000, 0, 7, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h90000000, 1, 6, 1, 6, S_ZLO, 0,             L_PC,         0,    0);
    add(32'h90000000, 1, 7, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h98000000, 0, 3, 1, 3, 0,     R_GRA | R_ROUT, L_PC,        0,    0);
    add(32'h98000000, 0, 4, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'hA0000000, 0, 3, 1, 3, S_PC,  R_GRB | R_RIN,  0,           0,    0);
    add(32'hA0000000, 0, 4, 1, 4, 0,     R_GRA | R_ROUT, L_PC,        0,    0);
    add(32'hA8000000, 0, 3, 1, 3, S_IN,  R_GRA | R_RIN,  0,           0,    0);
    add(32'hB0000000, 0, 3, 1, 3, 0,     R_GRA | R_ROUT, L_OUT,       0,    0);
    add(32'hB8000000, 0, 3, 1, 3, S_HI,  R_GRA | R_RIN,  0,           0,    0);
    add(32'hC0000000, 0, 3, 1, 3, S_LO,  R_GRA | R_RIN,  0,           0,    0);
    add(32'hC8000000, 0, 3, 1, 3, 0,     0,             0,            0,    0);
    add(32'hC8000000, 0, 4, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'hF8000000, 0, 3, 1, 3, 0,     0,             0,            0,    0);
    add(32'hD0000000, 0, 3, 1, 3, 0,     0,             0,            0,    0);
    add(32'hD0000000, 0, 4, 0, 0, 0,     0,             0,            0,    0);
`ifdef CTRL_SEQ_MULDIV_EN
    add(32'h70000000, 0, 3, 1, 3, 0,     R_GRA | R_ROUT, L_Y,         0,    0);
    add(32'h70000000, 0, 4, 1, 4, 0,     R_GRB | R_ROUT, L_Z,         0,    A_MUL);
    add(32'h70000000, 0, 5, 1, 5, S_ZLO, 0,             L_LO,         0,    0);
    add(32'h70000000, 0, 6, 1, 6, S_ZHI, 0,             L_HI,         0,    0);
    add(32'h70000000, 0, 7, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h78000000, 0, 4, 1, 4, 0,     R_GRB | R_ROUT, L_Z,         0,    A_DIV);
`else
    add(32'h70000000, 0, 3, 1, 3, 0,     0,             0,            0,    0);
    add(32'h70000000, 0, 4, 1, 0, S_PC,  0,             L_MAR | L_Z,  0,    A_INC);
    add(32'h78000000, 0, 3, 1, 3, 0,     0,             0,            0,    0);
`endif

    foreach (vecs[i]) begin
      start(vecs[i].ir, vecs[i].con);
      repeat (vecs[i].k) @(posedge clk);
      @(negedge clk);
      $display("vec %0d ir=%h con=%0d k=%0d out=%h", i, vecs[i].ir, vecs[i].con, vecs[i].k, dut_out());
      check($sformatf("vec%0d_ir%h_k%0d", i, vecs[i].ir, vecs[i].k), dut_out(),
            {vecs[i].run, vecs[i].step, vecs[i].src, vecs[i].rc, vecs[i].ld, vecs[i].mem, vecs[i].alu});
    end

    // Store: write pulses for exactly one cycle, at T7
    start(32'h10000000, 0);
    wcount = 0;
    wcycle = -1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (sif.mem_ctl[1]) begin
        wcount++;
        wcycle = c;
      end
    end
    $display("st write: count=%0d cycle=%0d", wcount, wcycle);
    check("st_write_count", 43'(wcount), 43'd1);
    check("st_write_at_t7", 43'(wcycle), 43'd7);

    // Halt opcode: HALT holds all outputs zero with run low
    start(32'hD0000000, 0);
    repeat (4) @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("halt_hold_c%0d", c), dut_out(), 43'd0);
    end
    $display("halt: held for 20 cycles out=%h", dut_out());

    // stop raised at ld T4: ld completes through T7, then HALT
    start(32'h00000000, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ld_stop_t4_step", 43'({sif.run, sif.step}), 43'({1'b1, 3'd4}));
    sif.stop = 1'b1;
    @(negedge clk);
    check("ld_stop_t5", dut_out(), {1'b1, 3'd5, S_ZLO, 6'd0, L_MAR, 2'd0, 13'd0});
    @(negedge clk);
    check("ld_stop_t6", dut_out(), {1'b1, 3'd6, 8'd0, 6'd0, L_MDR, M_RD, 13'd0});
    @(negedge clk);
    check("ld_stop_t7", dut_out(), {1'b1, 3'd7, S_MDR, R_GRA | R_RIN, 10'd0, 2'd0, 13'd0});
    @(negedge clk);
    check("ld_stop_halt", dut_out(), 43'd0);
    sif.stop = 1'b0;
    @(negedge clk);
    check("ld_stop_halt_hold", dut_out(), 43'd0);
    $display("stop during ld: final out=%h", dut_out());

    // clear pulsed during st T6: immediate zero outputs, no write, refetch at T0
    start(32'h10000000, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("st_t6_before_clear", 43'({sif.step, sif.ld_en[7], sif.mem_ctl}), 43'({3'd6, 1'b1, 2'b00}));
    #1 clear = 1'b1;
    #1 check("clear_async_zero", dut_out(), 43'd0);
    sif.IR = 32'h18000000;
    wr_seen = 0;
    @(negedge clk);
    if (sif.mem_ctl[1]) wr_seen = 1;
    clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("clear_refetch_t0", dut_out(), {1'b1, 3'd0, S_PC, 6'd0, L_MAR | L_Z, 2'd0, A_INC});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sif.mem_ctl[1]) wr_seen = 1;
    end
    $display("clear mid-st: write seen=%0d", wr_seen);
    check("clear_no_write", 43'(wr_seen), 43'd0);

`ifdef CTRL_SEQ_MULDIV_EN
    check("muldiv_bits_seen", 43'(mul_seen > 0), 43'd1);
`else
    check("muldiv_never", 43'(mul_seen), 43'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
